mux_4to1: RTL and testbench



---
 rtl/mux4to1_pkg.sv | 12 +
 rtl/mux4to1_core.sv | 27 ++
 rtl/mux_4to1.sv | 66 ++++++
 tb/tb_mux_4to1.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mux4to1_pkg.sv
// mux4to1_pkg: select-code type and constants shared by the
// four-way selector and its register stage.
package mux4to1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4to1_core.sv
// mux4to1_core: purely combinational four-way selector,
// bitwise across WIDTH, every select code valid.
module mux4to1_core
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] f
);

    // steer the indexed source to f
    always_comb begin
        f = '0;
        unique case (sel)
            SEL_A: f = a;
            SEL_B: f = b;
            SEL_C: f = c;
            SEL_D: f = d;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: four-way selector plus registered shadow path.
// MUX4TO1_REG_OUT_EN: when defined, y is taken from y_q.
module mux_4to1
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q,
    output logic             y_chg
);

    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] y_d;
    sel_t             sel_d;
    logic             chg_d;
    logic             chg_q;

    mux4to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (A),
        .b   (B),
        .c   (C),
        .d   (D),
        .sel (sel),
        .f   (f)
    );

    // next state: capture f and sel, flag a change against old y_q
    always_comb begin
        y_d   = f;
        sel_d = sel;
        chg_d = (f != y_q);
    end

    // shadow registers, cleared at once by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= SEL_A;
            chg_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
            chg_q <= chg_d;
        end
    end

    assign y_chg = chg_q;

`ifdef MUX4TO1_REG_OUT_EN
    assign y = y_q;
`else
    assign y = f;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: directed checks of the selector, the shadow
// registers, the change strobe and asynchronous reset.
module tb_mux_4to1;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a_i, b_i, c_i, d_i;
    logic [1:0]   sel_i;
    logic [W-1:0] y, y_q;
    logic [1:0]   sel_q;
    logic         y_chg;

    logic [W-1:0] exp_yq;
    logic [1:0]   exp_sel;
    logic         exp_chg;

    int total;
    int passed;

    mux_4to1 #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a_i),
        .B     (b_i),
        .C     (c_i),
        .D     (d_i),
        .sel   (sel_i),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q),
        .y_chg (y_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_f();
        case (sel_i)
            2'b00:   return a_i;
            2'b01:   return b_i;
            2'b10:   return c_i;
            default: return d_i;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_y();
`ifdef MUX4TO1_REG_OUT_EN
        return exp_yq;
`else
        return model_f();
`endif
    endfunction

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h",
                    tag, obs, exp);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".y_q"}, y_q, exp_yq);
        chk({tag, ".sel_q"}, {6'd0, sel_q}, {6'd0, exp_sel});
        chk({tag, ".y_chg"}, {7'd0, y_chg}, {7'd0, exp_chg});
        chk({tag, ".y"}, y, exp_y());
    endtask

    // called at a negedge; returns at the following negedge
    task automatic apply(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] c,
                         input logic [W-1:0] d,
                         input logic [1:0] s);
        logic [W-1:0] nf;
        a_i = a; b_i = b; c_i = c; d_i = d; sel_i = s;
        #1;
        chk({tag, ".y_now"}, y, exp_y());
        @(posedge clk);
        nf      = model_f();
        exp_chg = (nf != exp_yq);
        exp_yq  = nf;
        exp_sel = s;
        #1;
        chk_regs(tag);
        @(negedge clk);
    endtask

    task automatic edge_only(input string tag);
        logic [W-1:0] nf;
        @(posedge clk);
        nf      = model_f();
        exp_chg = (nf != exp_yq);
        exp_yq  = nf;
        exp_sel = sel_i;
        #1;
        chk_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        a_i = '0; b_i = '0; c_i = '0; d_i = '0;
        sel_i   = 2'b00;
        exp_yq  = '0;
        exp_sel = 2'b00;
        exp_chg = 1'b0;

        #2;
        chk_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply("zero", 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        apply("selB", 8'h00, 8'h01, 8'h00, 8'h00, 2'b01);
        apply("selC", 8'h00, 8'h00, 8'h01, 8'h00, 2'b10);
        apply("selD", 8'h00, 8'h00, 8'h00, 8'h01, 2'b11);

        for (int p = 0; p < 16; p++) begin
            for (int s = 0; s < 4; s++) begin
                apply("sweep",
                      {7'd0, p[0]}, {7'd0, p[1]},
                      {7'd0, p[2]}, {7'd0, p[3]},
                      s[1:0]);
            end
        end

        apply("pre_rst", 8'h01, 8'h00, 8'h00, 8'h00, 2'b00);
        #2;
        rst_n   = 1'b0;
        exp_yq  = '0;
        exp_sel = 2'b00;
        exp_chg = 1'b0;
        #1;
        chk_regs("async_rst");
        @(posedge clk);
        #1;
        chk_regs("hold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        edge_only("rel1");
        edge_only("rel2");

        apply("same0", 8'h01, 8'h01, 8'h00, 8'h00, 2'b00);
        apply("same1", 8'h01, 8'h01, 8'h00, 8'h00, 2'b01);

        apply("w8_a", 8'hA5, 8'h00, 8'h00, 8'h3C, 2'b00);
        apply("w8_d", 8'hA5, 8'h00, 8'h00, 8'h3C, 2'b11);
        apply("w8_mix", 8'hF0, 8'h0F, 8'h5A, 8'h3C, 2'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
